fetch_pc_gen: RTL
=================

# fetch_pc_gen

Parametrised fetch-stage program-counter generator: the next generation of the single-register PC. It holds the current fetch address and selects the next one from reset, trap, execute-stage redirect, stall hold, return-address-stack prediction, predecoded call target or sequential increment. It sits at the head of the IF stage, drives the instruction-memory address, and takes StallF from the hazard unit. It adds a one-entry pending-redirect buffer so redirects arriving during a stall are not lost, and a RAS_DEPTH-entry circular return address stack.

## Interface
- WIDTH, 32: address width.
- RESET_VECTOR, 32'h00400020: first fetch address after reset.
- TRAP_VECTOR, 32'h80000180: fetch address on trap.
- INCR, 4: sequential increment.
- RAS_DEPTH, 4: return-stack entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- StallF  in  1  hold the PC this cycle.
- trap  in  1  exception; redirect to TRAP_VECTOR.
- redirect  in  1  execute-stage branch/jump resolution.
- redirectPC  in  WIDTH  target for redirect.
- isCall  in  1  predecode: instruction at currPC is a call.
- callTarget  in  WIDTH  predecoded call target.
- isRet  in  1  predecode: instruction at currPC is a return.
- currPC  out  WIDTH  current fetch address (registered).
- pcValid  out  1  currPC is a real fetch address.
- redirectPending  out  1  buffered redirect waiting for stall release.
- rasEmpty  out  1  stack count == 0.
- rasFull  out  1  stack count == RAS_DEPTH.

## Operation
- Reset (rst_n=0 at edge): currPC<=RESET_VECTOR, pcValid<=0, pending buffer cleared, RAS count<=0, RAS pointer<=0. RAS entry contents are don't-care.
- First edge with rst_n=1 and pcValid=0: pcValid<=1. currPC is held, so RESET_VECTOR is fetched exactly once. All other inputs are ignored on this edge.
- With pcValid=1, the next PC is chosen by strict priority:
  1. trap: TRAP_VECTOR. Applies even if StallF=1. Clears the pending buffer.
  2. StallF=1: hold currPC. If redirect=1, latch redirectPC into the pending buffer (a newer redirect overwrites an older one) and set redirectPending.
  3. redirect=1: redirectPC. Clears pending; a live redirect beats a buffered one.
  4. redirectPending=1: the buffered PC. Clears pending.
  5. isRet=1 and !rasEmpty: pop; the next PC is the top entry.
  6. isCall=1: push currPC+INCR, next PC = callTarget.
  7. Otherwise: currPC+INCR.
- isRet with rasEmpty: no pop; the next PC is currPC+INCR.
- isCall and isRet both set: isRet wins, and no push occurs.
- Push/pop happen only when case 5 or 6 is selected. Stalls, traps and redirects never modify the RAS; no RAS repair on misprediction.
- Push when rasFull overwrites the oldest entry (circular wrap). The count stays at RAS_DEPTH.
- Arithmetic is modulo 2^WIDTH; currPC+INCR wraps silently.

## Timing
- Latency is one cycle: the selection made in cycle n is visible on currPC in cycle n+1.
- No combinational path from any input to any output.
- redirectPending, rasEmpty and rasFull are registered and update on the same edge as currPC.
- Reset mid-operation discards pending redirects and the RAS on that edge. pcValid drops for one cycle after reset deasserts.
- Pending redirect takes effect on the first edge with StallF=0, unless trap or a live redirect is present on that edge.

## Test plan
- Reset and release: rst_n=0 for 2 cycles, then 1 with no other inputs.
  - currPC=0x00400020 with pcValid=0, then pcValid=1 at 0x00400020.
  - Next cycles: 0x00400024, 0x00400028.
- Stall with buffered redirect: at PC 0x00400030, StallF=1 for 3 cycles, with redirect=1, redirectPC=0x00400100 in the first stalled cycle.
  - PC holds 0x00400030 while stalled; redirectPending=1.
  - Cycle after release: 0x00400100, redirectPending=0.
- Priority: trap=1 and redirect=1 together with StallF=1.
  - Next PC is 0x80000180 and redirectPending=0.
  - Repeat with trap=0, StallF=0: next PC is redirectPC.
- Call/return: at 0x00400040, isCall=1, callTarget=0x00400200.
  - Next PC 0x00400200.
  - Later isRet=1: next PC 0x00400044, rasEmpty=1.
  - isRet again with the stack empty: next PC = currPC+4.
- RAS overflow: 5 calls from 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 with RAS_DEPTH=4.
  - rasFull=1 after the 4th call.
  - 4 returns yield 0x5004, 0x4004, 0x3004, 0x2004, then rasEmpty=1.
- Wrap: currPC=0xFFFFFFFC with no events.
  - Next PC is 0x00000000.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: bundle between the PC generator and its neighbours.
// master drives stall/trap/redirect/predecode; slave (fetch_pc_gen) drives currPC and status.
interface fetch_pc_gen_if #(
   parameter int WIDTH = 32
);
   logic             StallF;
   logic             trap;
   logic             redirect;
   logic [WIDTH-1:0] redirectPC;
   logic             isCall;
   logic [WIDTH-1:0] callTarget;
   logic             isRet;
   logic [WIDTH-1:0] currPC;
   logic             pcValid;
   logic             redirectPending;
   logic             rasEmpty;
   logic             rasFull;

   modport master (
      output StallF, trap, redirect, redirectPC,
      output isCall, callTarget, isRet,
      input  currPC, pcValid, redirectPending,
      input  rasEmpty, rasFull
   );

   modport slave (
      input  StallF, trap, redirect, redirectPC,
      input  isCall, callTarget, isRet,
      output currPC, pcValid, redirectPending,
      output rasEmpty, rasFull
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage PC register with pending-redirect buffer and return stack.
// Ports: clk, rst_n (sync, active low); bus (slave) carries stall/trap/redirect/predecode in, PC/status out.
module fetch_pc_gen #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400020,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h80000180,
   parameter int               INCR         = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input logic           clk,
   input logic           rst_n,
   fetch_pc_gen_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [WIDTH-1:0] seq_pc;
   logic             valid_q;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d, top_idx;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;

   assign seq_pc  = pc_q + WIDTH'(INCR);
   // ptr_q is the next free slot, so the top lives one below it
   assign top_idx = ptr_q - PW'(1);

   always_comb begin
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      push      = 1'b0;
      pop       = 1'b0;
      if (!valid_q) begin
         // first edge after reset: hold so RESET_VECTOR is fetched once
         pc_d = pc_q;
      end else if (bus.trap) begin
         pc_d   = TRAP_VECTOR;
         pend_d = 1'b0;
      end else if (bus.StallF) begin
         if (bus.redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = bus.redirectPC;
         end
      end else if (bus.redirect) begin
         pc_d   = bus.redirectPC;
         pend_d = 1'b0;
      end else if (pend_q) begin
         pc_d   = pend_pc_q;
         pend_d = 1'b0;
      end else if (bus.isRet) begin
         // a return always suppresses a simultaneous call push
         if (cnt_q != '0) begin
            pop  = 1'b1;
            pc_d = ras_q[top_idx];
         end else begin
            pc_d = seq_pc;
         end
      end else if (bus.isCall) begin
         push = 1'b1;
         pc_d = bus.callTarget;
      end else begin
         pc_d = seq_pc;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (push) begin
         // full stack wraps and overwrites the oldest entry
         ptr_d = ptr_q + PW'(1);
         cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
      end else if (pop) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_VECTOR;
         valid_q   <= 1'b0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
      end else begin
         pc_q      <= pc_d;
         valid_q   <= 1'b1;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         ras_q[ptr_q] <= seq_pc;
      end
   end

   assign bus.currPC          = pc_q;
   assign bus.pcValid         = valid_q;
   assign bus.redirectPending = pend_q;
   assign bus.rasEmpty        = (cnt_q == '0);
   assign bus.rasFull         = (cnt_q == FULL);
endmodule
